// File: rtl/psm_capture_if.sv
// Gate-bus capture interface: enable and gate lines in, measurements and flags out.
interface psm_capture_if #(
  parameter int BITS_DATA = 16,
  parameter int DT_BITS   = 8
);
  logic                 iEN;
  logic [7:0]           iPSM;
  logic [BITS_DATA-1:0] oPERIOD;
  logic [BITS_DATA-1:0] oSHIFT1;
  logic [BITS_DATA-1:0] oSHIFT2;
  logic [BITS_DATA-1:0] oSHIFT3;
  logic [DT_BITS-1:0]   oDEADTIME;
  logic                 oVALID;
  logic                 oSHOOT;
  logic                 oTIMEOUT;

  modport master (
    output iEN, iPSM,
    input  oPERIOD, oSHIFT1, oSHIFT2, oSHIFT3, oDEADTIME, oVALID, oSHOOT, oTIMEOUT
  );

  modport slave (
    input  iEN, iPSM,
    output oPERIOD, oSHIFT1, oSHIFT2, oSHIFT3, oDEADTIME, oVALID, oSHOOT, oTIMEOUT
  );
endinterface

// File: rtl/psm_capture.sv
// PSM gate-pattern decoder: recovers period, leg 1-3 phase shifts and leg-0 deadtime
// from the 8-line gate bus, and flags shoot-through and loss of switching.
module psm_capture #(
  parameter int                   BITS_DATA = 16,
  parameter int                   DT_BITS   = 8,
  parameter logic [BITS_DATA-1:0] TIMEOUT   = 16'hFFF0
) (
  input  logic          CLK,
  input  logic          RST,
  psm_capture_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t               state;
  logic [7:0]           s1, s2;
  // Delay stage kept only for the lines whose edges are decoded
  logic [3:0]           s3_hs;
  logic                 s3_ls0;
  logic [BITS_DATA-1:0] cnt;
  logic [DT_BITS-1:0]   dt_cnt;
  logic                 fell_ls0;
  logic [BITS_DATA-1:0] shift [1:3];
  logic [3:1]           got;

  logic [3:0]           rise_hs;
  logic                 rise0, fall_ls0, gap0;
  logic [BITS_DATA-1:0] cnt_p1;
  logic [DT_BITS-1:0]   dt_now;

  always_comb begin
    rise_hs = '0;
    for (int unsigned k = 0; k < 4; k++)
      rise_hs[k] = s2[2*k] & ~s3_hs[k];
    rise0    = rise_hs[0];
    fall_ls0 = ~s2[1] & s3_ls0;
    gap0     = ~s2[0] & ~s2[1];
    cnt_p1   = cnt + BITS_DATA'(1);
    dt_now   = fell_ls0 ? dt_cnt : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      s1            <= '0;
      s2            <= '0;
      s3_hs         <= '0;
      s3_ls0        <= 1'b0;
      cnt           <= '0;
      dt_cnt        <= '0;
      fell_ls0      <= 1'b0;
      got           <= '0;
      for (int unsigned k = 1; k <= 3; k++) shift[k] <= '0;
      bus.oPERIOD   <= '0;
      bus.oSHIFT1   <= '0;
      bus.oSHIFT2   <= '0;
      bus.oSHIFT3   <= '0;
      bus.oDEADTIME <= '0;
      bus.oVALID    <= 1'b0;
      bus.oSHOOT    <= 1'b0;
      bus.oTIMEOUT  <= 1'b0;
    end else begin
      s1     <= bus.iPSM;
      s2     <= s1;
      s3_hs  <= {s2[6], s2[4], s2[2], s2[0]};
      s3_ls0 <= s2[1];

      if (rise0)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt_p1;

      // The fall cycle itself is already part of the gap, so it counts as one
      if (fall_ls0)
        dt_cnt <= gap0 ? DT_BITS'(1) : '0;
      else if (gap0 && dt_cnt != '1)
        dt_cnt <= dt_cnt + DT_BITS'(1);

      if (rise0)
        fell_ls0 <= 1'b0;
      else if (fall_ls0)
        fell_ls0 <= 1'b1;

      // Shift is the delay in cycles, so it shares the cnt+1 convention of the period
      for (int unsigned k = 1; k <= 3; k++) begin
        if (rise_hs[k] && rise0) begin
          shift[k] <= '0;
          got[k]   <= 1'b1;
        end else if (rise_hs[k] && !got[k]) begin
          shift[k] <= cnt_p1;
          got[k]   <= 1'b1;
        end else if (rise0) begin
          got[k]   <= 1'b0;
        end
      end

      bus.oVALID <= 1'b0;
      if (!bus.iEN) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (rise0) state <= ARM;
          ARM: begin
            if (rise0) begin
              state <= RUN;
            end else if (cnt == TIMEOUT) begin
              bus.oTIMEOUT <= 1'b1;
              state        <= IDLE;
            end
          end
          RUN: begin
            if (rise0) begin
              bus.oPERIOD   <= cnt_p1;
              bus.oSHIFT1   <= got[1] ? shift[1] : '1;
              bus.oSHIFT2   <= got[2] ? shift[2] : '1;
              bus.oSHIFT3   <= got[3] ? shift[3] : '1;
              bus.oDEADTIME <= dt_now;
              bus.oVALID    <= 1'b1;
              bus.oTIMEOUT  <= 1'b0;
            end else if (cnt == TIMEOUT) begin
              bus.oTIMEOUT <= 1'b1;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end

      for (int unsigned k = 0; k < 4; k++)
        if (s2[2*k] && s2[2*k+1]) bus.oSHOOT <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psm_capture.sv
// Self-checking bench for psm_capture: waveforms are built per switching period from
// (period, deadtime, leg shifts) and the expected results come from those parameters.
module tb_psm_capture;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  psm_capture_if #(.BITS_DATA(16), .DT_BITS(8)) bus ();

  psm_capture #(.BITS_DATA(16), .DT_BITS(8), .TIMEOUT(16'd1000)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    int unsigned due;
    int          p, d, s1, s2, s3;
  } exp_t;

  exp_t        q[$];
  int unsigned checks = 0, failures = 0, cyc = 0, last_rise = 0;
  int          nrise = 0;
  int          pp = 0, pd = 0, ps1 = 0, ps2 = 0, ps3 = 0;
  logic [15:0] lp = '0, ls1 = '0, ls2 = '0, ls3 = '0;
  logic [7:0]  ld = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] sh(input int s);
    return (s < 0) ? 16'hFFFF : 16'(s);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, 32'(bus.oPERIOD), 0);
    chk({tag, "_shift1"}, 32'(bus.oSHIFT1), 0);
    chk({tag, "_shift2"}, 32'(bus.oSHIFT2), 0);
    chk({tag, "_shift3"}, 32'(bus.oSHIFT3), 0);
    chk({tag, "_dt"}, 32'(bus.oDEADTIME), 0);
    chk({tag, "_valid"}, 32'(bus.oVALID), 0);
    chk({tag, "_shoot"}, 32'(bus.oSHOOT), 0);
    chk({tag, "_timeout"}, 32'(bus.oTIMEOUT), 0);
  endtask

  // One clock: drive pins away from the edge, sample just after it, check the strobe
  task automatic step(input logic [7:0] pins);
    exp_t e;
    @(negedge CLK);
    bus.iPSM = pins;
    @(posedge CLK);
    #1;
    cyc++;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("valid", 32'(bus.oVALID), 1);
      chk("period", 32'(bus.oPERIOD), 32'(e.p));
      chk("shift1", 32'(bus.oSHIFT1), 32'(sh(e.s1)));
      chk("shift2", 32'(bus.oSHIFT2), 32'(sh(e.s2)));
      chk("shift3", 32'(bus.oSHIFT3), 32'(sh(e.s3)));
      chk("deadtime", 32'(bus.oDEADTIME), 32'(e.d));
      chk("timeout_clr", 32'(bus.oTIMEOUT), 0);
      lp = 16'(e.p); ls1 = sh(e.s1); ls2 = sh(e.s2); ls3 = sh(e.s3); ld = 8'(e.d);
    end else begin
      chk("novalid", 32'(bus.oVALID), 0);
    end
  endtask

  // Leg 0 rises at t=0; leg k high side rises at t=s_k (s_k<0: held low);
  // leg-0 low side ends D cycles before the next leg-0 rise when lowon is set.
  task automatic run_period(input int P, input int D, input int s1, input int s2,
                            input int s3, input bit lowon, input int rst_at);
    int         h;
    int         s[3];
    logic [7:0] pins;
    h = P / 2;
    s = '{s1, s2, s3};
    nrise++;
    if (nrise >= 3)
      q.push_back('{due: cyc + 3, p: pp, d: pd, s1: ps1, s2: ps2, s3: ps3});
    pp = P; pd = lowon ? D : 0; ps1 = s1; ps2 = s2; ps3 = s3;
    last_rise = cyc + 1;
    for (int t = 0; t < P; t++) begin
      pins    = '0;
      pins[0] = (t < h);
      pins[1] = lowon && (t >= h + 3) && (t < P - D);
      for (int k = 1; k <= 3; k++)
        if (s[k-1] >= 0 && t >= s[k-1] && t < s[k-1] + (P - s[k-1]) / 2) pins[2*k] = 1'b1;
      if (t == rst_at) begin
        q.delete();
        nrise = 0;
        RST   = 1'b1;
        step(pins);
        chk_zero("midrst");
        RST   = 1'b0;
      end else begin
        step(pins);
      end
    end
  endtask

  function automatic int rand_shift(input int P);
    int unsigned r;
    r = $urandom % 6;
    if (r == 0) return -1;
    if (r == 1) return 0;
    return int'($urandom % 32'(P - 3));
  endfunction

  initial begin
    int P, D, a, b, c;
    bit lo;

    RST = 1'b1;
    bus.iEN  = 1'b1;
    bus.iPSM = '0;
    step('0);
    step('0);
    chk_zero("reset");
    RST = 1'b0;

    for (int i = 0; i < 5; i++) run_period(200, 10, 40, 100, 150, 1'b1, -1);
    for (int i = 0; i < 3; i++) run_period(200, 10, 40, -1, 150, 1'b1, -1);
    for (int i = 0; i < 3; i++) run_period(200, 10, 40, 100, 0, 1'b1, -1);

    for (int i = 0; i < 20; i++) begin
      P  = 60 + int'($urandom % 241);
      D  = 1 + int'($urandom % 20);
      lo = ($urandom % 5) != 0;
      a  = rand_shift(P);
      b  = rand_shift(P);
      c  = rand_shift(P);
      run_period(P, D, a, b, c, lo, -1);
    end

    // Switching stops: flag around TIMEOUT cycles after the last rise, results held
    while (cyc < last_rise + 1100) begin
      step('0);
      if (cyc == last_rise + 995) chk("to_early", 32'(bus.oTIMEOUT), 0);
      if (cyc == last_rise + 1010) begin
        chk("to_set", 32'(bus.oTIMEOUT), 1);
        chk("to_hold_period", 32'(bus.oPERIOD), 32'(lp));
        chk("to_hold_shift1", 32'(bus.oSHIFT1), 32'(ls1));
        chk("to_hold_shift2", 32'(bus.oSHIFT2), 32'(ls2));
        chk("to_hold_shift3", 32'(bus.oSHIFT3), 32'(ls3));
        chk("to_hold_dt", 32'(bus.oDEADTIME), 32'(ld));
      end
    end
    nrise = 0;

    run_period(150, 8, 30, 60, 90, 1'b1, -1);
    run_period(150, 8, 30, 60, 90, 1'b1, -1);
    chk("to_still_set", 32'(bus.oTIMEOUT), 1);
    run_period(150, 8, 30, 60, 90, 1'b1, -1);
    run_period(150, 8, 30, 60, 90, 1'b1, -1);

    run_period(200, 10, 40, 100, 150, 1'b1, 150);
    for (int i = 0; i < 4; i++) run_period(200, 10, 40, 100, 150, 1'b1, -1);

    for (int i = 0; i < 5; i++) step('0);
    step(8'h0C);
    step('0);
    chk("shoot_early", 32'(bus.oSHOOT), 0);
    step('0);
    chk("shoot_set", 32'(bus.oSHOOT), 1);
    bus.iEN = 1'b0;
    for (int i = 0; i < 3; i++) step('0);
    bus.iEN = 1'b1;
    step('0);
    chk("shoot_sticky", 32'(bus.oSHOOT), 1);
    RST = 1'b1;
    step('0);
    chk_zero("final_rst");
    RST = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
